// File: rtl/adder_flit_scheduler_if.sv
// Requester, adder and result bundle for the shared-adder flit scheduler.
// master drives requests and the adder sum; slave is the scheduler.
interface adder_flit_scheduler_if #(
   parameter int N = 21,
   parameter int R = 2
);
   localparam int IW = (R > 1) ? $clog2(R) : 1;

   logic [R-1:0]   req_valid;
   logic [R-1:0]   req_last;
   logic [R*N-1:0] req_op1;
   logic [R*N-1:0] req_op2;
   logic [R-1:0]   req_ready;
   logic [N-1:0]   add_in1;
   logic [N-1:0]   add_in2;
   logic [N-1:0]   add_sum;
   logic           res_valid;
   logic [IW-1:0]  res_id;
   logic [N-1:0]   res_sum;
   logic           res_last;
   logic           err_trunc;
   logic [31:0]    busy_cycles;
   logic [31:0]    flit_count;

   modport master (
      output req_valid, req_last, req_op1, req_op2, add_sum,
      input  req_ready, add_in1, add_in2, res_valid, res_id,
      input  res_sum, res_last, err_trunc, busy_cycles, flit_count
   );

   modport slave (
      input  req_valid, req_last, req_op1, req_op2, add_sum,
      output req_ready, add_in1, add_in2, res_valid, res_id,
      output res_sum, res_last, err_trunc, busy_cycles, flit_count
   );
endinterface

// File: rtl/adder_flit_scheduler.sv
// Round-robin packet scheduler sharing one external adder between R requesters,
// with a programmable post-packet idle gap and utilisation counters.
module adder_flit_scheduler #(
   parameter int N          = 21,
   parameter int R          = 2,
   parameter int MAX_FLITS  = 20,
   parameter int GAP_CYCLES = 7
) (
   input logic                   clk,
   input logic                   rst,
   adder_flit_scheduler_if.slave bus
);
   localparam int IW = (R > 1) ? $clog2(R) : 1;
   localparam int FW = $clog2(MAX_FLITS + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic [R-1:0]  ready_q, ready_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [N-1:0]  in1_q, in1_d;
   logic [N-1:0]  in2_q, in2_d;
   logic          tag_v_q, tag_v_d;
   logic [IW-1:0] tag_id_q, tag_id_d;
   logic          tag_last_q, tag_last_d;
   logic          rv_q, rv_d;
   logic [IW-1:0] rid_q, rid_d;
   logic [N-1:0]  rsum_q, rsum_d;
   logic          rlast_q, rlast_d;
   logic          err_q, err_d;
   logic [31:0]   busy_q, busy_d;
   logic [31:0]   flits_q, flits_d;

   logic [IW-1:0] win, cand;
   logic          found;
   logic          acc, last_in, close;
   logic [FW-1:0] fnext;

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      win   = ptr_q;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < R; k++) begin
         cand = IW'((int'(ptr_q) + k) % R);
         if (!found && bus.req_valid[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign acc     = |(bus.req_valid & ready_q);
   assign last_in = bus.req_last[gnt_q];
   assign fnext   = fcnt_q + 1'b1;
   assign close   = acc & (last_in | (fnext == FW'(MAX_FLITS)));

   // Next-state: arbitration, flit streaming, gap timing, result capture.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      ready_d    = ready_q;
      fcnt_d     = fcnt_q;
      gcnt_d     = gcnt_q;
      in1_d      = in1_q;
      in2_d      = in2_q;
      tag_v_d    = acc;
      tag_id_d   = tag_id_q;
      tag_last_d = tag_last_q;
      err_d      = err_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = win;
               ptr_d   = IW'((int'(win) + 1) % R);
               ready_d = R'(1) << win;
               fcnt_d  = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (acc) begin
               in1_d      = bus.req_op1[int'(gnt_q)*N +: N];
               in2_d      = bus.req_op2[int'(gnt_q)*N +: N];
               fcnt_d     = fnext;
               tag_id_d   = gnt_q;
               tag_last_d = close;
               if (close) begin
                  ready_d = '0;
                  gcnt_d  = '0;
                  if (!last_in) err_d = 1'b1;
                  state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
               end
            end
         end
         GAP: begin
            if (gcnt_q == GW'(GL)) state_d = IDLE;
            else gcnt_d = gcnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      rv_d    = tag_v_q;
      rsum_d  = tag_v_q ? bus.add_sum  : rsum_q;
      rid_d   = tag_v_q ? tag_id_q     : rid_q;
      rlast_d = tag_v_q ? tag_last_q   : rlast_q;

      busy_d  = busy_q;
      if (state_q == STREAM && busy_q != '1) busy_d = busy_q + 32'd1;
      flits_d = flits_q;
      if (acc && flits_q != '1) flits_d = flits_q + 32'd1;
   end

   // All state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         ready_q    <= '0;
         fcnt_q     <= '0;
         gcnt_q     <= '0;
         in1_q      <= '0;
         in2_q      <= '0;
         tag_v_q    <= 1'b0;
         tag_id_q   <= '0;
         tag_last_q <= 1'b0;
         rv_q       <= 1'b0;
         rid_q      <= '0;
         rsum_q     <= '0;
         rlast_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= '0;
         flits_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         ready_q    <= ready_d;
         fcnt_q     <= fcnt_d;
         gcnt_q     <= gcnt_d;
         in1_q      <= in1_d;
         in2_q      <= in2_d;
         tag_v_q    <= tag_v_d;
         tag_id_q   <= tag_id_d;
         tag_last_q <= tag_last_d;
         rv_q       <= rv_d;
         rid_q      <= rid_d;
         rsum_q     <= rsum_d;
         rlast_q    <= rlast_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         flits_q    <= flits_d;
      end
   end

   assign bus.req_ready   = ready_q;
   assign bus.add_in1     = in1_q;
   assign bus.add_in2     = in2_q;
   assign bus.res_valid   = rv_q;
   assign bus.res_id      = rid_q;
   assign bus.res_sum     = rsum_q;
   assign bus.res_last    = rlast_q;
   assign bus.err_trunc   = err_q;
   assign bus.busy_cycles = busy_q;
   assign bus.flit_count  = flits_q;
endmodule

// File: tb/tb_adder_flit_scheduler.sv
// Scoreboard bench for adder_flit_scheduler: GAP_CYCLES=7 instance plus a
// GAP_CYCLES=0 instance for the back-to-back single-flit case.
module tb_adder_flit_scheduler;
   localparam int N = 21;
   localparam int R = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_flit_scheduler_if #(.N(N), .R(R)) b ();
   adder_flit_scheduler_if #(.N(N), .R(R)) b0 ();

   assign b.add_sum  = b.add_in1 + b.add_in2;
   assign b0.add_sum = b0.add_in1 + b0.add_in2;

   adder_flit_scheduler #(.N(N), .R(R), .MAX_FLITS(20), .GAP_CYCLES(7)) u_dut (
      .clk(clk), .rst(rst), .bus(b)
   );
   adder_flit_scheduler #(.N(N), .R(R), .MAX_FLITS(20), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   typedef struct {
      logic [N-1:0] sum;
      int           id;
      bit           last;
      int           due;
   } exp_t;

   exp_t         sb[$];
   exp_t         sb0[$];
   int           acc_cyc[$];
   int           acc_id[$];
   int           acc0_cyc[$];
   logic [N-1:0] rs_sum[$];
   int           rs_id[$];
   bit           rs_last[$];
   int           rs_cyc[$];
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;
   int           pk_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard for the GAP_CYCLES=7 instance.
   always @(negedge clk) begin
      exp_t         e;
      logic [N-1:0] s;
      bit           l;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         checks++;
         if (b.res_valid !== 1'b1 || b.res_sum !== e.sum ||
             int'(b.res_id) != e.id || b.res_last !== e.last) begin
            failures++;
            $display("FAIL sb_result v=%b sum=%h id=%0d last=%b required v=1 sum=%h id=%0d last=%b",
                     b.res_valid, b.res_sum, b.res_id, b.res_last, e.sum, e.id, e.last);
         end
      end else if (b.res_valid !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL sb_spurious res_valid=%b required=0 cyc=%0d", b.res_valid, cyc);
      end
      if (b.res_valid === 1'b1) begin
         rs_sum.push_back(b.res_sum);
         rs_id.push_back(int'(b.res_id));
         rs_last.push_back(b.res_last);
         rs_cyc.push_back(cyc);
      end
      if (rst) begin
         sb.delete();
         pk_n = 0;
      end else begin
         for (int i = 0; i < R; i++) begin
            if (b.req_valid[i] === 1'b1 && b.req_ready[i] === 1'b1) begin
               s = b.req_op1[i*N +: N] + b.req_op2[i*N +: N];
               pk_n++;
               l = b.req_last[i] || pk_n == 20;
               if (l) pk_n = 0;
               sb.push_back('{s, i, l, cyc + 2});
               acc_cyc.push_back(cyc + 1);
               acc_id.push_back(i);
            end
         end
      end
   end

   // Scoreboard for the GAP_CYCLES=0 instance.
   always @(negedge clk) begin
      exp_t         e;
      logic [N-1:0] s;
      if (sb0.size() > 0 && sb0[0].due == cyc) begin
         e = sb0.pop_front();
         checks++;
         if (b0.res_valid !== 1'b1 || b0.res_sum !== e.sum ||
             int'(b0.res_id) != e.id || b0.res_last !== e.last) begin
            failures++;
            $display("FAIL sb0_result v=%b sum=%h id=%0d last=%b required v=1 sum=%h id=%0d last=%b",
                     b0.res_valid, b0.res_sum, b0.res_id, b0.res_last, e.sum, e.id, e.last);
         end
      end else if (b0.res_valid !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL sb0_spurious res_valid=%b required=0", b0.res_valid);
      end
      if (rst) sb0.delete();
      else begin
         for (int i = 0; i < R; i++) begin
            if (b0.req_valid[i] === 1'b1 && b0.req_ready[i] === 1'b1) begin
               s = b0.req_op1[i*N +: N] + b0.req_op2[i*N +: N];
               sb0.push_back('{s, i, b0.req_last[i], cyc + 2});
               acc0_cyc.push_back(cyc + 1);
            end
         end
      end
   end

   task automatic clear_logs();
      acc_cyc.delete();
      acc_id.delete();
      acc0_cyc.delete();
      rs_sum.delete();
      rs_id.delete();
      rs_last.delete();
      rs_cyc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_flit(input bit sel, input int i, input logic [N-1:0] a,
                            input logic [N-1:0] c, input bit last);
      bit ok = 1'b0;
      if (!sel) begin
         b.req_valid[i]       = 1'b1;
         b.req_last[i]        = last;
         b.req_op1[i*N +: N]  = a;
         b.req_op2[i*N +: N]  = c;
      end else begin
         b0.req_valid[i]      = 1'b1;
         b0.req_last[i]       = last;
         b0.req_op1[i*N +: N] = a;
         b0.req_op2[i*N +: N] = c;
      end
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = sel ? b0.req_ready[i] : b.req_ready[i];
      end
      @(posedge clk);
      #1;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept_timeout req=%0d accepted=0 required=1", i);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (b.req_ready !== 2'b00 || b.res_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hs ready=%b res_valid=%b required 00/0", b.req_ready, b.res_valid);
      end
      checks++;
      if ({b.res_sum, b.res_id, b.res_last, b.add_in1, b.add_in2} !== '0) begin
         failures++;
         $display("FAIL reset_data sum=%h id=%0d in1=%h in2=%h required 0",
                  b.res_sum, b.res_id, b.add_in1, b.add_in2);
      end
      checks++;
      if ({b.busy_cycles, b.flit_count, b.err_trunc} !== '0) begin
         failures++;
         $display("FAIL reset_cnt busy=%0d flits=%0d err=%b required 0",
                  b.busy_cycles, b.flit_count, b.err_trunc);
      end
   endtask

   task automatic test_round_robin();
      int exp_id[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      clear_logs();
      fork
         begin
            for (int p = 0; p < 2; p++) begin
               send_flit(0, 0, N'(p*4 + 1), 21'd10, 1'b0);
               send_flit(0, 0, N'(p*4 + 2), 21'd20, 1'b1);
            end
            b.req_valid[0] = 1'b0;
         end
         begin
            for (int p = 0; p < 2; p++) begin
               send_flit(0, 1, N'(p*4 + 3), 21'd30, 1'b0);
               send_flit(0, 1, N'(p*4 + 4), 21'd40, 1'b1);
            end
            b.req_valid[1] = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (acc_id.size() != 8) begin
         failures++;
         $display("FAIL rr_count accepts=%0d required=8", acc_id.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (acc_id[k] != exp_id[k]) begin
               failures++;
               $display("FAIL rr_order idx=%0d id=%0d required=%0d", k, acc_id[k], exp_id[k]);
            end
         end
         for (int k = 1; k < 8; k++) begin
            checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != ((k % 2 == 0) ? 9 : 1)) begin
               failures++;
               $display("FAIL rr_spacing idx=%0d gap=%0d required=%0d", k,
                        acc_cyc[k] - acc_cyc[k-1], (k % 2 == 0) ? 9 : 1);
            end
         end
      end
   endtask

   task automatic test_single_packet();
      logic [N-1:0] exp_s[3] = '{21'h000003, 21'h000000, 21'h00000A};
      bit           exp_l[3] = '{1'b0, 1'b0, 1'b1};
      do_reset();
      clear_logs();
      send_flit(0, 0, 21'd1, 21'd2, 1'b0);
      send_flit(0, 0, 21'h1FFFFF, 21'd1, 1'b0);
      send_flit(0, 0, 21'd5, 21'd5, 1'b1);
      b.req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rs_sum.size() != 3 || acc_cyc.size() != 3) begin
         failures++;
         $display("FAIL single_count results=%0d accepts=%0d required=3",
                  rs_sum.size(), acc_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (rs_sum[k] !== exp_s[k] || rs_id[k] != 0 || rs_last[k] != exp_l[k] ||
                rs_cyc[k] != acc_cyc[k] + 1) begin
               failures++;
               $display("FAIL single_res idx=%0d sum=%h id=%0d last=%b lat=%0d required sum=%h id=0 last=%b lat=1",
                        k, rs_sum[k], rs_id[k], rs_last[k], rs_cyc[k] - acc_cyc[k],
                        exp_s[k], exp_l[k]);
            end
         end
         checks++;
         if (acc_cyc[2] - acc_cyc[0] != 2) begin
            failures++;
            $display("FAIL single_b2b span=%0d required=2", acc_cyc[2] - acc_cyc[0]);
         end
      end
      checks++;
      if (b.flit_count !== 32'd3 || b.busy_cycles !== 32'd3) begin
         failures++;
         $display("FAIL single_cnt flits=%0d busy=%0d required 3/3", b.flit_count, b.busy_cycles);
      end
   endtask

   task automatic test_truncate();
      int nlast;
      int nid;
      clear_logs();
      for (int k = 0; k < 25; k++) begin
         send_flit(0, 1, N'(k + 100), N'(k), 1'b0);
         if (k == 18) begin
            checks++;
            if (b.err_trunc !== 1'b0) begin
               failures++;
               $display("FAIL trunc_early err=%b required=0", b.err_trunc);
            end
         end
      end
      b.req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (b.err_trunc !== 1'b1) begin
         failures++;
         $display("FAIL trunc_err err=%b required=1", b.err_trunc);
      end
      checks++;
      if (acc_cyc.size() != 25 || rs_last.size() != 25) begin
         failures++;
         $display("FAIL trunc_count accepts=%0d results=%0d required=25",
                  acc_cyc.size(), rs_last.size());
      end else begin
         nlast = 0;
         nid = 0;
         for (int k = 0; k < 25; k++) begin
            if (rs_last[k]) nlast++;
            if (rs_id[k] == 1) nid++;
         end
         checks++;
         if (!rs_last[19] || nlast != 1 || nid != 25) begin
            failures++;
            $display("FAIL trunc_last last19=%b nlast=%0d nid1=%0d required 1/1/25",
                     rs_last[19], nlast, nid);
         end
         checks++;
         if (acc_cyc[20] - acc_cyc[19] != 9) begin
            failures++;
            $display("FAIL trunc_gap gap=%0d required=9", acc_cyc[20] - acc_cyc[19]);
         end
      end
      do_reset();
      checks++;
      if (b.err_trunc !== 1'b0) begin
         failures++;
         $display("FAIL trunc_clear err=%b required=0", b.err_trunc);
      end
   endtask

   task automatic test_stall();
      logic [31:0] bz;
      clear_logs();
      for (int k = 0; k < 3; k++) send_flit(0, 0, N'(k + 7), N'(k + 9), 1'b0);
      b.req_valid[0]      = 1'b0;
      b.req_op1[0 +: N]   = 21'h1ABCDE;
      b.req_op2[0 +: N]   = 21'h0F0F0F;
      bz = b.busy_cycles;
      for (int j = 0; j < 4; j++) begin
         @(posedge clk);
         #1;
         b.req_op1[0 +: N] = N'($urandom);
         checks++;
         if (b.add_in1 !== 21'd9 || b.add_in2 !== 21'd11 || b.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL stall_hold in1=%h in2=%h ready=%b required 9/b/01",
                     b.add_in1, b.add_in2, b.req_ready);
         end
         if (j > 0) begin
            checks++;
            if (b.res_valid !== 1'b0) begin
               failures++;
               $display("FAIL stall_res res_valid=%b required=0", b.res_valid);
            end
         end
      end
      checks++;
      if (b.busy_cycles !== bz + 32'd4) begin
         failures++;
         $display("FAIL stall_busy busy=%0d required=%0d", b.busy_cycles, bz + 32'd4);
      end
      for (int k = 3; k < 6; k++) send_flit(0, 0, N'(k + 7), N'(k + 9), k == 5);
      b.req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (acc_id.size() != 6 || rs_last.size() != 6) begin
         failures++;
         $display("FAIL stall_count accepts=%0d results=%0d required=6",
                  acc_id.size(), rs_last.size());
      end else begin
         checks++;
         if (acc_id[3] != 0 || acc_id[5] != 0 || acc_cyc[3] - acc_cyc[2] != 5 ||
             rs_last[4] || !rs_last[5]) begin
            failures++;
            $display("FAIL stall_resume id3=%0d gap=%0d last4=%b last5=%b required 0/5/0/1",
                     acc_id[3], acc_cyc[3] - acc_cyc[2], rs_last[4], rs_last[5]);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 5; k++) send_flit(0, 0, N'(k), N'(k), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
      checks++;
      if ({b.req_ready, b.res_valid, b.res_sum, b.res_id, b.res_last,
           b.add_in1, b.add_in2, b.err_trunc, b.busy_cycles, b.flit_count} !== '0) begin
         failures++;
         $display("FAIL mrst_zero ready=%b v=%b sum=%h in1=%h busy=%0d flits=%0d required 0",
                  b.req_ready, b.res_valid, b.res_sum, b.add_in1, b.busy_cycles, b.flit_count);
      end
      fork
         begin
            send_flit(0, 0, 21'h55, 21'd1, 1'b1);
            b.req_valid[0] = 1'b0;
         end
         begin
            send_flit(0, 1, 21'h66, 21'd2, 1'b1);
            b.req_valid[1] = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (acc_id.size() != 2 || rs_sum.size() != 2) begin
         failures++;
         $display("FAIL mrst_count accepts=%0d results=%0d required=2",
                  acc_id.size(), rs_sum.size());
      end else begin
         checks++;
         if (acc_id[0] != 0 || acc_id[1] != 1) begin
            failures++;
            $display("FAIL mrst_arb first=%0d second=%0d required 0/1", acc_id[0], acc_id[1]);
         end
      end
   endtask

   task automatic test_gap_zero();
      clear_logs();
      for (int p = 0; p < 4; p++) send_flit(1, 0, N'(p), N'(p + 1), 1'b1);
      b0.req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (acc0_cyc.size() != 4) begin
         failures++;
         $display("FAIL gap0_count accepts=%0d required=4", acc0_cyc.size());
      end else begin
         for (int k = 1; k < 4; k++) begin
            checks++;
            if (acc0_cyc[k] - acc0_cyc[k-1] != 2) begin
               failures++;
               $display("FAIL gap0_spacing idx=%0d gap=%0d required=2", k,
                        acc0_cyc[k] - acc0_cyc[k-1]);
            end
         end
      end
      checks++;
      if (b0.busy_cycles !== 32'd4 || b0.flit_count !== 32'd4) begin
         failures++;
         $display("FAIL gap0_cnt busy=%0d flits=%0d required 4/4", b0.busy_cycles, b0.flit_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      b.req_valid  = '0;
      b.req_last   = '0;
      b.req_op1    = '0;
      b.req_op2    = '0;
      b0.req_valid = '0;
      b0.req_last  = '0;
      b0.req_op1   = '0;
      b0.req_op2   = '0;
      test_reset();
      test_round_robin();
      repeat (12) @(posedge clk);
      test_single_packet();
      repeat (12) @(posedge clk);
      test_truncate();
      test_stall();
      repeat (12) @(posedge clk);
      test_mid_reset();
      repeat (12) @(posedge clk);
      test_gap_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
